parallel_in_serial_out_ctrl: RTL and testbench
==============================================

// Module: parallel_in_serial_out_ctrl
// PURPOSE
//  - Upstream feeder for the 4-bit serial-in/parallel-out shift register with enable.
//  - Accepts a parallel word over a valid/ready handshake and emits it one bit per clock.
//  - Drives that stage's ShiftIn/ShiftEn pins, so the downstream register rebuilds the word on ParallelOut.
//  - FSM-sequenced, with a bit counter and programmable inter-word gap.
// PARAMETERS
//  - WIDTH      4  data bits per word (2..16).
//  - MSB_FIRST  1  1: bit WIDTH-1 sent first; 0: bit 0 sent first.
//  - GAP_CYCLES 2  idle cycles (ShiftEn=0) forced after each word (0..15).
// PORTS
//  - Clk         in   1      system clock, rising-edge.
//  - Reset       in   1      asynchronous, active-high reset.
//  - ParallelIn  in   WIDTH  word to serialize; sampled only on handshake.
//  - LoadValid   in   1      producer has a word on ParallelIn.
//  - LoadReady   out  1      block can accept a word (IDLE only).
//  - ShiftIn     out  1      serial data bit to downstream SIPO.
//  - ShiftEn     out  1      downstream shift enable; high exactly on data/parity cycles.
//  - Busy        out  1      high in any state other than IDLE.
//  - Done        out  1      one-cycle pulse after the last bit of a word.
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE; shift reg, counters=0.
//    Outputs: ShiftIn=0, ShiftEn=0, Busy=0, Done=0, LoadReady=1.
//  - Reset mid-word: the partial word is discarded and not resumed.
//  - All outputs are registered except LoadReady, which is decoded from state (IDLE).
//  - States:
//    - IDLE -> SHIFT on LoadValid&&LoadReady at edge k; ParallelIn is latched at edge k.
//    - SHIFT: ShiftEn=1, ShiftIn=current bit, for cycles k+1..k+WIDTH.
//      Counter counts WIDTH-1 down to 0; bit order is set by MSB_FIRST.
//    - SHIFT -> PARITY when the count hits 0 (PARITY_EN only); otherwise -> GAP.
//    - PARITY: one cycle, ShiftEn=1, ShiftIn=^word (even parity) -> GAP.
//    - GAP: ShiftEn=0, ShiftIn=0, for GAP_CYCLES cycles -> IDLE.
//      If GAP_CYCLES=0, go straight to IDLE.
//  - Done pulses for exactly one cycle: the first cycle after the last ShiftEn=1 cycle.
//  - Back-to-back words:
//    - Next handshake at the earliest in the first IDLE cycle.
//    - Throughput is one word per WIDTH(+1)+GAP_CYCLES+1 cycles.
//  - LoadValid while not ready: ignored. The producer must hold the word until the handshake.
//  - ParallelIn changing during SHIFT has no effect (latched copy is used).
//  - ShiftIn is 0 whenever ShiftEn=0.
// CONFIGURATION
//  - PARITY_ERR_EN defined:
//    - PARITY state present; each word is WIDTH+1 serial bits.
//    - The downstream register must be WIDTH+1 wide to capture the parity bit.
//  - PARITY_ERR_EN undefined:
//    - No PARITY state; exactly WIDTH ShiftEn cycles per word.
// STRUCTURE
//  - Package piso_pkg:
//    - state typedef (IDLE, SHIFT, PARITY, GAP).
//    - Counter width constants: CNT_W = $clog2(16), GAP_W = 4.
//  - Sub-module piso_down_counter:
//    - Loadable down-counter with zero flag and async reset.
//    - Instanced twice: bit count and gap count.
//  - Top level: FSM, latched shift register, parity XOR.
// TESTING
//  - Use WIDTH=4 with the downstream SIPO instanced as a checker. 20 ns clock.
//  - T1 reset:
//    - Assert Reset mid-cycle -> all outputs 0, LoadReady=1 immediately.
//  - T2 MSB_FIRST=1, load 4'b1011:
//    - ShiftIn 1,0,1,1 with ShiftEn=1 for 4 cycles.
//    - Done pulses next cycle; SIPO ParallelOut=4'b1011.
//  - T3 MSB_FIRST=0, load 4'b0001:
//    - ShiftIn 1,0,0,0; SIPO ParallelOut=4'b1000.
//  - T4 back-to-back, LoadValid held high with words 4'hA then 4'h5:
//    - 2 ShiftEn=0 gap cycles, then the next word.
//    - LoadReady low from handshake until IDLE.
//  - T5 Reset asserted on the 2nd data bit:
//    - ShiftEn=0 at once; FSM in IDLE; no Done pulse.
//    - Next word 4'hC serializes cleanly.
//  - T6 PARITY_ERR_EN, load 4'b0111:
//    - 5 ShiftEn cycles; 5th bit=1 (odd ones count).

Source files
------------

// File: rtl/parallel_in_serial_out_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// parallel_in_serial_out_ctrl_pkg
//
// Purpose : Shared types and constants for the parallel-in / serial-out
//           feeder. Holds the FSM state encoding and the counter widths.
//           The bit counter is sized for words up to 16 bits. The gap
//           counter is sized for up to 15 idle cycles.
// Ports   : none (package)
// Options : PARITY_ERR_EN (used by the top level) adds the PARITY state
//           to the sequence.
// ----------------------------------------------------------------------------
package parallel_in_serial_out_ctrl_pkg;

    // PARITY is always part of the encoding, but the FSM only enters it when
    // the parity option is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(16);
    localparam int GAP_W = 4;

endpackage

// File: rtl/parallel_in_serial_out_ctrl_if.sv
// ----------------------------------------------------------------------------
// parallel_in_serial_out_ctrl_if
//
// Purpose : Bundles the load handshake and the serial output pins of the
//           feeder into one connection.
// Ports   : parallel_in  word to serialize (producer -> feeder)
//           load_valid   producer has a word on parallel_in
//           load_ready   feeder can accept a word (IDLE only)
//           shift_in     serial data bit to the downstream SIPO
//           shift_en     downstream shift enable
//           busy         feeder is not IDLE
//           done         one-cycle pulse after the last serial bit
// Modports: master = producer / observer side, slave = the feeder itself.
// ----------------------------------------------------------------------------
interface parallel_in_serial_out_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_in;
    logic             shift_en;
    logic             busy;
    logic             done;

    modport master (
        output parallel_in,
        output load_valid,
        input  load_ready,
        input  shift_in,
        input  shift_en,
        input  busy,
        input  done
    );

    modport slave (
        input  parallel_in,
        input  load_valid,
        output load_ready,
        output shift_in,
        output shift_en,
        output busy,
        output done
    );
endinterface

// File: rtl/parallel_in_serial_out_ctrl_down_counter.sv
// ----------------------------------------------------------------------------
// parallel_in_serial_out_ctrl_down_counter
//
// Purpose : Loadable down-counter with a zero flag. The feeder uses one copy
//           to count data bits and another to count gap cycles.
// Ports   : clk         rising-edge clock
//           rst         asynchronous active-high reset (count -> 0)
//           load        load load_value (has priority over dec)
//           load_value  value to load
//           dec         decrement by one, saturating at zero
//           zero        high while the count is zero
// ----------------------------------------------------------------------------
module parallel_in_serial_out_ctrl_down_counter
    import parallel_in_serial_out_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // A load always wins, so that the FSM can restart the count on the same
    // edge that it leaves the previous phase. A decrement at zero is ignored,
    // so the counter parks at zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/parallel_in_serial_out_ctrl.sv
// ----------------------------------------------------------------------------
// parallel_in_serial_out_ctrl
//
// Purpose : Upstream feeder for a serial-in/parallel-out shift register.
//           It takes one parallel word over a valid/ready handshake. It then
//           sends the word one bit per clock on shift_in, with shift_en high,
//           so that the downstream register rebuilds the word. After each
//           word it forces GAP_CYCLES idle cycles.
// Params  : WIDTH       data bits per word (2..16)
//           MSB_FIRST   1: bit WIDTH-1 goes first, 0: bit 0 goes first
//           GAP_CYCLES  idle cycles after each word (0..15)
// Ports   : clk         rising-edge clock
//           rst         asynchronous active-high reset
//           bus         slave side of parallel_in_serial_out_ctrl_if
//                       (parallel_in, load_valid, load_ready, shift_in,
//                        shift_en, busy, done)
// Options : `define PARITY_ERR_EN to append one even-parity bit after the
//           data bits. Each word then takes WIDTH+1 shift_en cycles, and the
//           downstream register must be WIDTH+1 bits wide.
// ----------------------------------------------------------------------------
module parallel_in_serial_out_ctrl
    import parallel_in_serial_out_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 2
) (
    input logic                         clk,
    input logic                         rst,
    parallel_in_serial_out_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t           state;
    logic [WIDTH-1:0] word_q;
    logic             shift_in_q;
    logic             shift_en_q;
    logic             busy_q;
    logic             done_q;
`ifdef PARITY_ERR_EN
    logic             parity_q;
`endif

    logic handshake;
    logic word_end;
    logic bit_load;
    logic bit_dec;
    logic bit_zero;
    logic gap_load;
    logic gap_dec;
    logic gap_zero;

    // Returns the bit of a word that goes out next, based on the shift order.
    function automatic logic next_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Moves the word so that the following bit is at the outgoing end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Counter control is decoded from the present state, so the counters stay
    // in step with the registered FSM.
    // - The bit counter is loaded on the handshake and counts one per data bit.
    // - The gap counter is loaded on the last shift_en cycle (data or parity)
    //   and then counts through GAP.
    always_comb begin
        handshake = (state == IDLE) && bus.load_valid;
`ifdef PARITY_ERR_EN
        word_end  = (state == PARITY);
`else
        word_end  = (state == SHIFT) && bit_zero;
`endif
        bit_load  = handshake;
        bit_dec   = (state == SHIFT) && !bit_zero;
        gap_load  = word_end;
        gap_dec   = (state == GAP) && !gap_zero;
    end

    parallel_in_serial_out_ctrl_down_counter #(
        .W(CNT_W)
    ) u_bit_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (bit_load),
        .load_value(BIT_LOAD),
        .dec       (bit_dec),
        .zero      (bit_zero)
    );

    parallel_in_serial_out_ctrl_down_counter #(
        .W(GAP_W)
    ) u_gap_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (gap_load),
        .load_value(GAP_LOAD),
        .dec       (gap_dec),
        .zero      (gap_zero)
    );

    // Sequencer and registered outputs.
    // - The first bit is put on shift_in on the handshake edge itself, so
    //   shift_en is high for exactly the WIDTH cycles that follow.
    // - The word is copied into word_q on that edge. After that, parallel_in
    //   is ignored until the next IDLE.
    // - On the edge after the last shift_en cycle, shift_en and shift_in go
    //   low and done is set for one cycle.
    // - When GAP_CYCLES is 0, the FSM returns straight to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_q     <= '0;
            shift_in_q <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PARITY_ERR_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state      <= SHIFT;
                        busy_q     <= 1'b1;
                        shift_en_q <= 1'b1;
                        shift_in_q <= next_bit(bus.parallel_in);
                        word_q     <= advance(bus.parallel_in);
`ifdef PARITY_ERR_EN
                        parity_q   <= ^bus.parallel_in;
`endif
                    end
                end
                SHIFT: begin
                    if (bit_zero) begin
`ifdef PARITY_ERR_EN
                        state      <= PARITY;
                        shift_in_q <= parity_q;
`else
                        shift_en_q <= 1'b0;
                        shift_in_q <= 1'b0;
                        done_q     <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state  <= GAP;
                        end
`endif
                    end else begin
                        shift_in_q <= next_bit(word_q);
                        word_q     <= advance(word_q);
                    end
                end
                PARITY: begin
                    shift_en_q <= 1'b0;
                    shift_in_q <= 1'b0;
                    done_q     <= 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (gap_zero) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // load_ready is the only output decoded from state. It goes high as soon
    // as the FSM is in IDLE, including straight after an asynchronous reset.
    assign bus.load_ready = (state == IDLE);
    assign bus.shift_in   = shift_in_q;
    assign bus.shift_en   = shift_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_parallel_in_serial_out_ctrl.sv
// ----------------------------------------------------------------------------
// tb_parallel_in_serial_out_ctrl
//
// Purpose : Self-checking bench for parallel_in_serial_out_ctrl.
//           - Two feeders, one MSB-first and one LSB-first, run in lockstep
//             from the same producer. Both use WIDTH=4 and GAP_CYCLES=2.
//           - Each lane feeds a SIPO model. On every done pulse, the word
//             rebuilt in the SIPO is compared with the frame expected for the
//             word that was handed over.
// Options : Follows PARITY_ERR_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_parallel_in_serial_out_ctrl;

    localparam int WIDTH      = 4;
    localparam int GAP_CYCLES = 2;
`ifdef PARITY_ERR_EN
    localparam int FRAME_W    = WIDTH + 1;
`else
    localparam int FRAME_W    = WIDTH;
`endif

    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        bit                 b2b;
    } exp_t;

    logic clk;
    logic rst;

    parallel_in_serial_out_ctrl_if #(.WIDTH(WIDTH)) bus_m ();
    parallel_in_serial_out_ctrl_if #(.WIDTH(WIDTH)) bus_l ();

    parallel_in_serial_out_ctrl #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (1'b1),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut_m (
        .clk(clk),
        .rst(rst),
        .bus(bus_m)
    );

    parallel_in_serial_out_ctrl #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (1'b0),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut_l (
        .clk(clk),
        .rst(rst),
        .bus(bus_l)
    );

    int   vectors_applied;
    int   miscompares;
    exp_t exp_q [2][$];
    bit   held;

    logic se [2];
    logic si [2];
    logic dn [2];

    assign se[0] = bus_m.shift_en;
    assign se[1] = bus_l.shift_en;
    assign si[0] = bus_m.shift_in;
    assign si[1] = bus_l.shift_in;
    assign dn[0] = bus_m.done;
    assign dn[1] = bus_l.done;

    // The clock period is 20 ns. Rising edges fall at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One comparison. Each call is counted, and each mismatch is reported.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Builds the frame the downstream SIPO should hold after one word. The
    // serial bit order comes from the shift order, and any parity bit goes
    // last. The SIPO shifts each new bit in at bit 0.
    function automatic logic [FRAME_W-1:0] expected_frame(input logic [WIDTH-1:0] w,
                                                          input bit msb_first);
        logic [FRAME_W-1:0] f;
        logic               b;
        f = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b = msb_first ? w[WIDTH-1-i] : w[i];
            f = {f[FRAME_W-2:0], b};
        end
`ifdef PARITY_ERR_EN
        begin
            int ones;
            ones = 0;
            for (int i = 0; i < WIDTH; i++) ones += int'(w[i]);
            f = {f[FRAME_W-2:0], ((ones % 2) == 1)};
        end
`endif
        return f;
    endfunction

    // Presents one word to both lanes and waits, with a bound, for the
    // handshake. On the handshake, the expected frames go into the
    // scoreboard.
    // - keep_valid leaves load_valid high, so that the next call is
    //   back-to-back.
    // - parallel_in is then scrambled, to show that the feeder works from its
    //   own copy of the word.
    task automatic apply_stimulus(input logic [WIDTH-1:0] w, input bit keep_valid);
        int   waited;
        exp_t e;
        bit   was_held;
        was_held          = held;
        bus_m.parallel_in = w;
        bus_l.parallel_in = w;
        bus_m.load_valid  = 1'b1;
        bus_l.load_valid  = 1'b1;
        waited = 0;
        while (!(bus_m.load_ready === 1'b1 && bus_l.load_ready === 1'b1) && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 64) begin
            check_output("handshake_timeout", 32'd1, 32'd0);
            bus_m.load_valid = 1'b0;
            bus_l.load_valid = 1'b0;
            held = 1'b0;
            return;
        end
        e.b2b   = was_held;
        e.frame = expected_frame(w, 1'b1);
        exp_q[0].push_back(e);
        e.frame = expected_frame(w, 1'b0);
        exp_q[1].push_back(e);
        @(negedge clk);
        check_output("ready_low_after_load", 32'({bus_m.load_ready, bus_l.load_ready}), 32'd0);
        check_output("busy_after_load", 32'({bus_m.busy, bus_l.busy}), 32'd3);
        held = keep_valid;
        if (!keep_valid) begin
            bus_m.load_valid = 1'b0;
            bus_l.load_valid = 1'b0;
        end
        bus_m.parallel_in = WIDTH'($urandom);
        bus_l.parallel_in = bus_m.parallel_in;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits, with a bound, until every handed-over word has been seen to
    // finish.
    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    endtask

    // Monitor. At every falling edge it feeds each lane's SIPO model. On
    // done, it checks:
    // - the rebuilt frame;
    // - the number of shift_en cycles;
    // - that done came right after the last shift_en cycle;
    // - that shift_in stayed 0 while shift_en was low;
    // - for back-to-back words, the start-to-start period.
    // Reset throws away any partly sent word and its scoreboard entry.
    initial begin
        logic [FRAME_W-1:0] sipo [2];
        int                 bits [2];
        bit                 stray [2];
        logic               prev_se [2];
        int                 cur_start [2];
        int                 prev_start [2];
        int                 cycle;
        exp_t               e;
        cycle = 0;
        for (int l = 0; l < 2; l++) begin
            sipo[l] = '0; bits[l] = 0; stray[l] = 1'b0; prev_se[l] = 1'b0;
            cur_start[l] = 0; prev_start[l] = 0;
        end
        forever begin
            @(negedge clk);
            cycle++;
            for (int l = 0; l < 2; l++) begin
                if (rst) begin
                    exp_q[l].delete();
                    sipo[l]    = '0;
                    bits[l]    = 0;
                    stray[l]   = 1'b0;
                    prev_se[l] = 1'b0;
                end else begin
                    if (dn[l] === 1'b1) begin
                        if (exp_q[l].size() == 0) begin
                            check_output($sformatf("unexpected_done_lane%0d", l), 32'd1, 32'd0);
                        end else begin
                            e = exp_q[l].pop_front();
                            check_output($sformatf("frame_lane%0d", l), 32'(sipo[l]), 32'(e.frame));
                            check_output($sformatf("frame_bits_lane%0d", l), 32'(bits[l]), 32'(FRAME_W));
                            check_output($sformatf("done_timing_lane%0d", l),
                                         32'({prev_se[l], se[l]}), 32'd2);
                            check_output($sformatf("idle_shift_in_lane%0d", l), 32'(stray[l]), 32'd0);
                            if (e.b2b) begin
                                check_output($sformatf("b2b_period_lane%0d", l),
                                             32'(cur_start[l] - prev_start[l]),
                                             32'(FRAME_W + GAP_CYCLES + 1));
                            end
                        end
                        bits[l]  = 0;
                        stray[l] = 1'b0;
                    end
                    if (se[l] === 1'b1) begin
                        if (bits[l] == 0) begin
                            prev_start[l] = cur_start[l];
                            cur_start[l]  = cycle;
                        end
                        sipo[l] = {sipo[l][FRAME_W-2:0], si[l]};
                        bits[l]++;
                    end else if (si[l] !== 1'b0) begin
                        stray[l] = 1'b1;
                    end
                    prev_se[l] = se[l];
                end
            end
        end
    end

    // Main sequence:
    // - reset checks;
    // - directed words (MSB/LSB order, back-to-back, parity pattern);
    // - a run of random words;
    // - reset part-way through a word, followed by a clean word.
    initial begin
        logic [WIDTH-1:0] w;
        bit               keep;
        vectors_applied   = 0;
        miscompares       = 0;
        held              = 1'b0;
        rst               = 1'b0;
        bus_m.load_valid  = 1'b0;
        bus_l.load_valid  = 1'b0;
        bus_m.parallel_in = '0;
        bus_l.parallel_in = '0;

        // Assert reset in the middle of a cycle. It must act at once.
        #5 rst = 1'b1;
        #1;
        check_output("reset_shift_en", 32'({bus_m.shift_en, bus_l.shift_en}), 32'd0);
        check_output("reset_shift_in", 32'({bus_m.shift_in, bus_l.shift_in}), 32'd0);
        check_output("reset_busy", 32'({bus_m.busy, bus_l.busy}), 32'd0);
        check_output("reset_done", 32'({bus_m.done, bus_l.done}), 32'd0);
        check_output("reset_load_ready", 32'({bus_m.load_ready, bus_l.load_ready}), 32'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // 1011 gives 1011 on the MSB-first lane. 0001 gives 1000 on the
        // LSB-first lane.
        apply_stimulus(4'b1011, 1'b0);
        idle_cycles(3);
        apply_stimulus(4'b0001, 1'b0);
        wait_drain();

        // Back-to-back words with load_valid held high.
        apply_stimulus(4'hA, 1'b1);
        apply_stimulus(4'h5, 1'b0);
        wait_drain();

        // Odd number of ones. The parity bit is 1 when parity is enabled.
        apply_stimulus(4'b0111, 1'b0);
        wait_drain();

        // Random words, with a random mix of back-to-back and idle spacing.
        for (int i = 0; i < 30; i++) begin
            w    = WIDTH'($urandom);
            keep = (i == 29) ? 1'b0 : 1'($urandom_range(0, 1));
            apply_stimulus(w, keep);
            if (!keep) idle_cycles($urandom_range(0, 3));
        end
        wait_drain();

        // Reset in the middle of the second data bit. Output stops at once,
        // with no done pulse. The next word then goes out cleanly.
        apply_stimulus(4'h6, 1'b0);
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        check_output("midword_reset_shift_en", 32'({bus_m.shift_en, bus_l.shift_en}), 32'd0);
        check_output("midword_reset_ready", 32'({bus_m.load_ready, bus_l.load_ready}), 32'd3);
        check_output("midword_reset_busy", 32'({bus_m.busy, bus_l.busy}), 32'd0);
        check_output("midword_reset_done", 32'({bus_m.done, bus_l.done}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(4);
        apply_stimulus(4'hC, 1'b0);
        wait_drain();
        idle_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
